// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the in-order issue hazard controller.
// Holds the FSM state encoding, instruction-class bit positions and register-file size.
package pipeline_hazard_ctrl_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = $clog2(NUM_REGS);
    localparam int INST_W    = 6;
    localparam int CNT_W     = 2;

    localparam int IT_LDR  = 0;
    localparam int IT_STR  = 1;
    localparam int IT_BL   = 2;
    localparam int IT_BX   = 3;
    localparam int IT_BLX  = 4;
    localparam int IT_RSVD = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BR_WAIT = 2'd2
    } state_t;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [INST_W-1:0]    inst_t;

    function automatic logic is_mem_op(input inst_t it);
        return it[IT_LDR] | it[IT_STR];
    endfunction

    function automatic logic is_branch(input inst_t it);
        return it[IT_BL] | it[IT_BX] | it[IT_BLX];
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller: instruction fields in, issue/stall/flush status out.
// The decode stage uses the master modport, the controller the slave modport.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic                dec_valid;
    logic [2:0]          used_RmRnRd;
    reg_idx_t            num_Rm;
    reg_idx_t            num_Rn;
    reg_idx_t            num_Rd;
    logic                write;
    reg_idx_t            writenum;
    inst_t               inst_type;
    logic                mem_done;
    logic                br_resolve;

    logic                issue;
    logic                dec_ready;
    logic                flush;
    logic [NUM_REGS-1:0] busy_mask;
    logic                mem_busy;

    modport master (
        output dec_valid, used_RmRnRd, num_Rm, num_Rn, num_Rd,
        output write, writenum, inst_type, mem_done, br_resolve,
        input  issue, dec_ready, flush, busy_mask, mem_busy
    );

    modport slave (
        input  dec_valid, used_RmRnRd, num_Rm, num_Rn, num_Rd,
        input  write, writenum, inst_type, mem_done, br_resolve,
        output issue, dec_ready, flush, busy_mask, mem_busy
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Per-register pending-write tracker: countdown for ALU results, flag for loads awaiting memory.
// busy_mask is purely registered state (no same-cycle bypass); no backpressure of its own.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_issue,
    input  logic                i_ld_issue,
    input  reg_idx_t            i_writenum,
    input  logic                i_mem_done,
    output logic [NUM_REGS-1:0] o_busy_mask
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WB_DEPTH);

    logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_REGS-1:0]            r_lp;
    logic [NUM_REGS-1:0]            w_sel;

    assign w_sel = NUM_REGS'(1) << i_writenum;

    // A new issue to a register wins over everything else, so the youngest writer always owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_lp  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_sel[r] && i_wr_issue) begin
                    r_cnt[r] <= RELOAD;
                    r_lp[r]  <= 1'b0;
                end else if (w_sel[r] && i_ld_issue) begin
                    r_cnt[r] <= '0;
                    r_lp[r]  <= 1'b1;
                end else if (i_mem_done && r_lp[r]) begin
                    r_cnt[r] <= CNT_W'(1);
                    r_lp[r]  <= 1'b0;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            o_busy_mask[r] = r_lp[r] | (r_cnt[r] != '0);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage issue control: RAW/structural stalls, memory-busy tracking, branch wait and flush.
// issue/dec_ready are combinational from registered state; flush lags br_resolve by one cycle.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_flush;
    logic                w_flush_nxt;
    logic                r_mem_busy;
    logic [NUM_REGS-1:0] w_busy_mask;

    logic w_src_hazard;
    logic w_struct_hazard;
    logic w_issue;
    logic w_is_nop;
    logic w_wr_issue;
    logic w_ld_issue;
    logic w_mem_issue;
    logic w_br_issue;

    assign w_src_hazard = (bus.used_RmRnRd[2] & w_busy_mask[bus.num_Rm])
                        | (bus.used_RmRnRd[1] & w_busy_mask[bus.num_Rn])
                        | (bus.used_RmRnRd[0] & w_busy_mask[bus.num_Rd]);

    assign w_struct_hazard = is_mem_op(bus.inst_type) & r_mem_busy;

    assign w_issue = bus.dec_valid & (r_state == ST_RUN) & ~w_src_hazard & ~w_struct_hazard;

    // The reserved class retires like a NOP: it issues but touches no tracking state.
    assign w_is_nop    = bus.inst_type[IT_RSVD];
    assign w_wr_issue  = w_issue & ~w_is_nop & bus.write & ~bus.inst_type[IT_LDR];
    assign w_ld_issue  = w_issue & ~w_is_nop & bus.inst_type[IT_LDR];
    assign w_mem_issue = w_issue & ~w_is_nop & is_mem_op(bus.inst_type);
    assign w_br_issue  = w_issue & ~w_is_nop & is_branch(bus.inst_type);

    hazard_scoreboard #(
        .WB_DEPTH    (WB_DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_issue  (w_wr_issue),
        .i_ld_issue  (w_ld_issue),
        .i_writenum  (bus.writenum),
        .i_mem_done  (bus.mem_done),
        .o_busy_mask (w_busy_mask)
    );

    // A new memory issue outranks a completion in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_busy <= 1'b0;
        end else if (w_mem_issue) begin
            r_mem_busy <= 1'b1;
        end else if (bus.mem_done) begin
            r_mem_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_br_issue) begin
                    w_state_nxt = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (bus.br_resolve) begin
                    w_state_nxt = ST_RUN;
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.issue     = w_issue;
    assign bus.dec_ready = (r_state == ST_RUN) & (w_issue | ~bus.dec_valid);
    assign bus.flush     = r_flush;
    assign bus.busy_mask = w_busy_mask;
    assign bus.mem_busy  = r_mem_busy;

endmodule
